// File: rtl/fifo_burst_reader.sv
// Burst reader sitting behind a single-clock FIFO: pulls fixed-length bursts into a 3-entry skid
// buffer and presents them as a valid/ready stream with a last marker. FIFO_BURST_RD_TIMEOUT_EN enables partial-burst flush.
module fifo_burst_reader #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned FIFO_DEPTH = 12,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    input  logic [FIFO_DEPTH:0]   fifo_use_words,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int unsigned LW = $clog2(BURST_LEN + 1);
    localparam int unsigned UW = FIFO_DEPTH + 1;
    localparam logic [UW-1:0] BURST_LEN_W = UW'(BURST_LEN);
    localparam logic [LW-1:0] BURST_LEN_L = LW'(BURST_LEN);
    localparam logic [LW-1:0] ONE_L       = LW'(1);

    if (BURST_LEN < 1 || BURST_LEN > (1 << FIFO_DEPTH) || TIMEOUT < 1) begin : g_bad_params
        $error("fifo_burst_reader: illegal BURST_LEN/FIFO_DEPTH/TIMEOUT");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state_q;
    logic [LW-1:0]         left_q;
    logic                  rd_q;
    logic                  last_tag_q;

    logic [DATA_WIDTH-1:0] buf_data_q [3];
    logic [DATA_WIDTH-1:0] buf_data_d [3];
    logic [2:0]            buf_last_q, buf_last_d;
    logic [1:0]            buf_cnt_q,  buf_cnt_d;

    logic                  start_full;
    logic                  room;
    logic                  pop;

    assign start_full = (fifo_use_words >= BURST_LEN_W);

    // One read may be in flight, so the buffer slot it will land in must be counted as taken.
    assign room    = ({1'b0, buf_cnt_q} + {2'b00, rd_q}) <= 3'd2;
    assign fifo_rd = (state_q == BURST) && (left_q != '0) && !fifo_empty && !clear && room;

    assign m_valid = (buf_cnt_q != 2'd0);
    assign m_data  = buf_data_q[0];
    assign m_last  = buf_last_q[0];
    assign pop     = m_valid && m_ready;
    assign busy    = (state_q == BURST) || rd_q || (buf_cnt_q != 2'd0);

`ifdef FIFO_BURST_RD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

    logic [TW-1:0] tmo_q;
    logic          start_tmo;

    assign start_tmo = (state_q == IDLE) && (tmo_q == TIMEOUT_T) && !fifo_empty && !start_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (clear || state_q != IDLE || fifo_empty || start_full || start_tmo) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            left_q     <= '0;
            rd_q       <= 1'b0;
            last_tag_q <= 1'b0;
        end else if (clear) begin
            state_q    <= IDLE;
            left_q     <= '0;
            rd_q       <= 1'b0;
            last_tag_q <= 1'b0;
        end else begin
            rd_q       <= fifo_rd;
            last_tag_q <= fifo_rd && (left_q == ONE_L);
            case (state_q)
                IDLE: begin
                    if (start_full) begin
                        state_q <= BURST;
                        left_q  <= BURST_LEN_L;
                    end
`ifdef FIFO_BURST_RD_TIMEOUT_EN
                    else if (start_tmo) begin
                        state_q <= BURST;
                        left_q  <= LW'(fifo_use_words);
                    end
`endif
                end
                BURST: begin
                    if (fifo_rd) begin
                        left_q <= left_q - ONE_L;
                        if (left_q == ONE_L) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Head is always entry 0: a pop shifts down first, then a push lands behind the survivors.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        buf_cnt_d  = buf_cnt_q;
        if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_data_d[1] = buf_data_q[2];
            buf_last_d    = {buf_last_q[2], buf_last_q[2:1]};
            buf_cnt_d     = buf_cnt_q - 2'd1;
        end
        if (rd_q) begin
            case (buf_cnt_d)
                2'd0: begin
                    buf_data_d[0] = fifo_data;
                    buf_last_d[0] = last_tag_q;
                end
                2'd1: begin
                    buf_data_d[1] = fifo_data;
                    buf_last_d[1] = last_tag_q;
                end
                default: begin
                    buf_data_d[2] = fifo_data;
                    buf_last_d[2] = last_tag_q;
                end
            endcase
            buf_cnt_d = buf_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_data_q <= '{default: '0};
            buf_last_q <= '0;
            buf_cnt_q  <= '0;
        end else if (clear) begin
            buf_last_q <= '0;
            buf_cnt_q  <= '0;
        end else begin
            buf_data_q <= buf_data_d;
            buf_last_q <= buf_last_d;
            buf_cnt_q  <= buf_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: behavioural FIFO, expected-beat queue filled at write time,
// negedge monitor that pops and compares on every stream handshake.
module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int FD = 4;
    localparam int BL = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic [FD:0]   fifo_use_words;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          busy;

    logic          wr_en;
    logic [DW-1:0] wr_data;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic [DW-1:0] fq[$];
    beat_t         exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;

    logic          rd_s [64];
    logic          v_s  [64];
    logic [DW-1:0] dat_s[64];

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(FD),
        .BURST_LEN (BL),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .fifo_rd       (fifo_rd),
        .fifo_data     (fifo_data),
        .fifo_empty    (fifo_empty),
        .fifo_use_words(fifo_use_words),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .busy          (busy)
    );

    // Behavioural single-clock FIFO with registered read data
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fq.delete();
            fifo_data      <= '0;
            fifo_empty     <= 1'b1;
            fifo_use_words <= '0;
        end else begin
            if (clear) begin
                fq.delete();
            end else begin
                if (fifo_rd && fq.size() > 0) fifo_data <= fq.pop_front();
                if (wr_en) fq.push_back(wr_data);
            end
            fifo_empty     <= (fq.size() == 0);
            fifo_use_words <= (FD+1)'(fq.size());
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted beat must match the oldest outstanding expected beat
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {m_last, m_data}, 64'hDEAD);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat", {m_last, m_data}, {e.l, e.d});
                end
            end
            if (clear) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic force_last);
        beat_t b;
        wr_data = $urandom;
        wr_en   = 1'b1;
        b.d     = wr_data;
        b.l     = force_last || ((wr_cnt % BL) == BL - 1);
        exp_q.push_back(b);
        wr_cnt++;
    endtask

    // Sample k is taken k cycles after the first write cycle begins
    task automatic run_rec(input int n_wr, input int n_cyc);
        for (int k = 0; k < n_cyc; k++) begin
            if (k < n_wr) put(1'b0);
            else wr_en = 1'b0;
            tick();
            rd_s[k+1]  = fifo_rd;
            v_s[k+1]   = m_valid;
            dat_s[k+1] = m_data;
        end
        wr_en = 1'b0;
    endtask

    function automatic logic [63:0] win(input int a0, input int a1, input int b0, input int b1);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++)
            if ((i >= a0 && i <= a1) || (i >= b0 && i <= b1)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] rd_mask(input int n);
        logic [63:0] m;
        m = '0;
        for (int i = 1; i <= n; i++) m[i] = rd_s[i];
        return m;
    endfunction

    function automatic logic [63:0] v_mask(input int n);
        logic [63:0] m;
        m = '0;
        for (int i = 1; i <= n; i++) m[i] = v_s[i];
        return m;
    endfunction

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || busy); i++) tick();
        check(name, {exp_q.size(), 31'd0, busy}, 64'd0);
    endtask

    task automatic quiet_window(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (fifo_rd || m_valid) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        int written;
        logic idle_prev;

        reset_n = 1'b0;
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        m_ready = 1'b0;
        #3;
        check("reset_ctrl", {fifo_rd, m_valid, m_last, busy}, 4'b0000);
        check("reset_data", m_data, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Full burst: start seen at sample 4, reads 5..8, beats 7..10
        m_ready = 1'b1;
        run_rec(4, 12);
        check("full_rd", rd_mask(12), win(5, 8, 99, 0));
        check("full_valid", v_mask(12), win(7, 10, 99, 0));
        drain("full_drain", 20);

        // Back-to-back: second burst reads 10..13, single bubble at 11
        run_rec(8, 20);
        check("b2b_rd", rd_mask(20), win(5, 8, 10, 13));
        check("b2b_valid", v_mask(20), win(7, 10, 12, 15));
        drain("b2b_drain", 20);

        // Back-pressure: three reads then stall, head word held
        m_ready = 1'b0;
        run_rec(4, 16);
        check("bp_rd", rd_mask(16), win(5, 7, 99, 0));
        check("bp_valid", v_mask(16), win(7, 16, 99, 0));
        mism = 0;
        for (int k = 7; k <= 16; k++) if (dat_s[k] !== dat_s[7]) mism++;
        check("bp_stable", mism, 0);
        check("bp_head", dat_s[7], exp_q[0].d);
        m_ready = 1'b1;
        drain("bp_drain", 30);

        // Partial burst
`ifdef FIFO_BURST_RD_TIMEOUT_EN
        put(1'b0);
        tick();
        put(1'b1);
        tick();
        wr_en = 1'b0;
        drain("partial_drain", 40);
        wr_cnt = 0;
`else
        put(1'b0);
        tick();
        put(1'b0);
        tick();
        wr_en = 1'b0;
        quiet_window("partial_hold", 100);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wr_cnt = 0;
        tick();
`endif

        // Clear one cycle after the second read
        m_ready = 1'b0;
        run_rec(4, 6);
        check("clr_rd", rd_mask(6), win(5, 6, 99, 0));
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wr_cnt = 0;
        check("clr_after", {m_valid, busy}, 2'b00);
        m_ready = 1'b1;
        quiet_window("clr_quiet", 20);

        // Asynchronous reset mid-burst
        run_rec(4, 7);
        reset_n = 1'b0;
        #1;
        check("arst_ctrl", {fifo_rd, m_valid, m_last, busy}, 4'b0000);
        check("arst_data", m_data, 0);
        wr_cnt = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        quiet_window("arst_idle", 20);
        run_rec(4, 12);
        check("arst_rd", rd_mask(12), win(5, 8, 99, 0));
        check("arst_valid", v_mask(12), win(7, 10, 99, 0));
        drain("arst_drain", 20);

        // Randomised traffic with random sink stalls
        written   = 0;
        idle_prev = 1'b0;
        for (int cyc = 0; cyc < 800 && written < 60; cyc++) begin
            m_ready = ($urandom_range(9, 0) < 7);
            if (fq.size() < 12 && (idle_prev || $urandom_range(1, 0) == 1)) begin
                put(1'b0);
                written++;
                idle_prev = 1'b0;
            end else begin
                wr_en     = 1'b0;
                idle_prev = (fq.size() < 12);
            end
            tick();
        end
        wr_en = 1'b0;
        check("rand_written", written, 60);
        m_ready = 1'b1;
        drain("rand_drain", 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
